// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC constants: instruction field layout, bubble encoding, PC width.
package simplerisc_pkg;
  localparam int PC_W       = 32;
  localparam int INSN_W     = 32;
  localparam int OPCODE_W   = 5;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;

  localparam logic [OPCODE_W-1:0] OPC_NOP  = 5'b01101;
  localparam logic [INSN_W-1:0]   NOP_INSN = {OPC_NOP, {(INSN_W-OPCODE_W){1'b0}}};
  localparam logic [PC_W-1:0]     RESET_PC = 32'h0000_0000;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSN_W-1:0] insn);
    return insn[OPCODE_MSB:OPCODE_LSB];
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch control in, imem request/return, IF/OF register out.
interface fetch_stage_if #(parameter int CNT_W = 16);
  import simplerisc_pkg::*;

  logic              stall_if;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_pc;
  logic [PC_W-1:0]   imem_addr;
  logic [INSN_W-1:0] imem_rdata;
  logic              imem_valid;
  logic [PC_W-1:0]   of_pc;
  logic [INSN_W-1:0] of_instruction;
  logic              of_valid;
  logic [CNT_W-1:0]  fetch_count;

  // master: the fetch stage itself
  modport master (
    input  stall_if, branch_taken, branch_pc, imem_rdata, imem_valid,
    output imem_addr, of_pc, of_instruction, of_valid, fetch_count
  );

  // slave: hazard unit, EX redirect, instruction memory and OF consumer
  modport slave (
    output stall_if, branch_taken, branch_pc, imem_rdata, imem_valid,
    input  imem_addr, of_pc, of_instruction, of_valid, fetch_count
  );
endinterface

// File: rtl/if_of_latch.sv
// IF/OF pipeline register: hold on stall, load a bubble on flush/miss, else load fetch.
module if_of_latch
  import simplerisc_pkg::*;
#(
  parameter logic [INSN_W-1:0] NOP = NOP_INSN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic [PC_W-1:0]   pc,
  input  logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   of_pc,
  output logic [INSN_W-1:0] of_instruction,
  output logic              of_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_pc          <= '0;
      of_instruction <= NOP;
      of_valid       <= 1'b0;
    end else if (hold) begin
      of_pc          <= of_pc;
      of_instruction <= of_instruction;
      of_valid       <= of_valid;
    end else if (bubble) begin
      // of_pc still tracks pc so OF sees where the bubble came from
      of_pc          <= pc;
      of_instruction <= NOP;
      of_valid       <= 1'b0;
    end else begin
      of_pc          <= pc;
      of_instruction <= insn;
      of_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// SimpleRISC instruction fetch: PC register, next-PC selection, fetch counter, IF/OF register.
module fetch_stage
  import simplerisc_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC_P = RESET_PC,
  parameter logic [PC_W-1:0]   PC_STEP    = 32'd1,
  parameter logic [INSN_W-1:0] NOP_P      = NOP_INSN,
  parameter int                CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cnt;
  logic             hold;
  logic             bubble;
  logic             fetch_go;

  // redirect beats stall; a miss only matters when not stalled
  assign hold     = bus.stall_if & ~bus.branch_taken;
  assign bubble   = bus.branch_taken | ~bus.imem_valid;
  assign fetch_go = ~hold & ~bubble;

  assign bus.imem_addr   = pc;
  assign bus.fetch_count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC_P;
      cnt <= '0;
    end else begin
      if (bus.branch_taken) pc <= bus.branch_pc;
      else if (fetch_go)    pc <= pc + PC_STEP;
      if (fetch_go && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  if_of_latch #(.NOP(NOP_P)) u_latch (
    .clk            (clk),
    .rst_n          (rst_n),
    .hold           (hold),
    .bubble         (bubble),
    .pc             (pc),
    .insn           (bus.imem_rdata),
    .of_pc          (bus.of_pc),
    .of_instruction (bus.of_instruction),
    .of_valid       (bus.of_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, redirect, miss, wrap and saturation.
module tb_fetch_stage;
  import simplerisc_pkg::*;

  localparam logic [31:0] NOP = 32'h6800_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fetch_stage_if #(.CNT_W(16)) bus ();

  fetch_stage #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // memory returns an address-tagged word; garbage when not valid
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {5'b00010, a[26:0] ^ 27'h0A5_5A5A};
  endfunction

  always_comb bus.imem_rdata = bus.imem_valid ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.stall_if = 0; bus.branch_taken = 0; bus.branch_pc = '0; bus.imem_valid = 1;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step(); step(); step();
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.imem_addr, 32'h0); end
    checks++; if (bus.of_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.of_valid); end
    checks++; if (bus.of_instruction !== NOP) begin errors++; $display("FAIL reset_insn: got %h want %h", bus.of_instruction, NOP); end
    checks++; if (bus.fetch_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", bus.fetch_count); end
    checks++; if (bus.of_pc !== 32'h0) begin errors++; $display("FAIL reset_ofpc: got %h want 0", bus.of_pc); end
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.of_pc !== 32'(i)) begin errors++; $display("FAIL seq_ofpc[%0d]: got %h want %h", i, bus.of_pc, i); end
      checks++; if (bus.of_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.of_valid); end
      checks++; if (bus.of_instruction !== mem_word(32'(i))) begin errors++; $display("FAIL seq_insn[%0d]: got %h want %h", i, bus.of_instruction, mem_word(32'(i))); end
    end
    checks++; if (bus.fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count: got %0d want 4", bus.fetch_count); end
    checks++; if (bus.imem_addr !== 32'd4) begin errors++; $display("FAIL seq_pc: got %h want 4", bus.imem_addr); end
  endtask

  task automatic test_stall();
    step(); // pc -> 5, of_pc=4, count=5
    bus.stall_if = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_addr !== 32'd5) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 5", i, bus.imem_addr); end
      checks++; if (bus.of_pc !== 32'd4 || bus.of_valid !== 1'b1 || bus.of_instruction !== mem_word(32'd4)) begin
        errors++; $display("FAIL stall_of[%0d]: got pc=%h v=%b i=%h want pc=4 v=1 i=%h", i, bus.of_pc, bus.of_valid, bus.of_instruction, mem_word(32'd4));
      end
      checks++; if (bus.fetch_count !== 16'd5) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 5", i, bus.fetch_count); end
    end
  endtask

  task automatic test_branch_over_stall();
    bus.stall_if = 1; bus.branch_taken = 1; bus.branch_pc = 32'h40;
    step();
    bus.stall_if = 0; bus.branch_taken = 0;
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL br_pc: got %h want 40", bus.imem_addr); end
    checks++; if (bus.of_valid !== 1'b0 || bus.of_instruction !== NOP) begin errors++; $display("FAIL br_flush: got v=%b i=%h want v=0 i=%h", bus.of_valid, bus.of_instruction, NOP); end
    checks++; if (bus.of_pc !== 32'd5) begin errors++; $display("FAIL br_ofpc: got %h want 5", bus.of_pc); end
    step();
    checks++; if (bus.of_pc !== 32'h40 || bus.of_valid !== 1'b1) begin errors++; $display("FAIL br_target: got pc=%h v=%b want pc=40 v=1", bus.of_pc, bus.of_valid); end
    checks++; if (bus.imem_addr !== 32'h41 || bus.fetch_count !== 16'd6) begin errors++; $display("FAIL br_next: got pc=%h cnt=%0d want 41/6", bus.imem_addr, bus.fetch_count); end
  endtask

  task automatic test_miss();
    bus.branch_taken = 1; bus.branch_pc = 32'd7;
    step();
    bus.branch_taken = 0; bus.imem_valid = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.of_instruction !== NOP || bus.of_valid !== 1'b0) begin errors++; $display("FAIL miss_bubble[%0d]: got v=%b i=%h want v=0 i=%h", i, bus.of_valid, bus.of_instruction, NOP); end
      checks++; if (bus.imem_addr !== 32'd7 || bus.of_pc !== 32'd7) begin errors++; $display("FAIL miss_pc[%0d]: got pc=%h ofpc=%h want 7/7", i, bus.imem_addr, bus.of_pc); end
    end
    checks++; if (bus.fetch_count !== 16'd6) begin errors++; $display("FAIL miss_count: got %0d want 6", bus.fetch_count); end
    bus.imem_valid = 1;
    step();
    checks++; if (bus.of_pc !== 32'd7 || bus.of_valid !== 1'b1 || bus.of_instruction !== mem_word(32'd7)) begin
      errors++; $display("FAIL miss_resume: got pc=%h v=%b i=%h want pc=7 v=1 i=%h", bus.of_pc, bus.of_valid, bus.of_instruction, mem_word(32'd7));
    end
    checks++; if (bus.fetch_count !== 16'd7) begin errors++; $display("FAIL miss_count2: got %0d want 7", bus.fetch_count); end
  endtask

  task automatic test_boundary();
    bus.branch_taken = 1; bus.branch_pc = 32'hFFFF_FFFF;
    step();
    bus.branch_taken = 0;
    step();
    checks++; if (bus.of_pc !== 32'hFFFF_FFFF || bus.of_valid !== 1'b1) begin errors++; $display("FAIL wrap_ofpc: got pc=%h v=%b want ffffffff/1", bus.of_pc, bus.of_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", bus.imem_addr); end
    checks++; if (bus.fetch_count !== 16'd8) begin errors++; $display("FAIL wrap_count: got %0d want 8", bus.fetch_count); end
    for (int i = 0; i < 65526; i++) @(posedge clk);
    #1;
    checks++; if (bus.fetch_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", bus.fetch_count); end
    step();
    checks++; if (bus.fetch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h want ffff", bus.fetch_count); end
    step();
    checks++; if (bus.fetch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bus.fetch_count); end
    checks++; if (bus.of_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", bus.of_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_miss();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
